// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the counter-width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_iter_div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // diff[WIDTH] is the borrow: set only when shifted < divisor
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// One shift-add or restoring step per cycle, WIDTH steps.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               valid_q, valid_d;
  logic               dbz_q, dbz_d;

  logic               is_div, is_sgn;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;
  logic [2*WIDTH-1:0] step_nxt, prod_fix;
  logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;
  logic               div_q;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i    (acc_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (div_rem),
    .q_o      (div_q)
  );

  // acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    is_div = (op == OP_DIV) | (op == OP_DIVU);
    is_sgn = (op == OP_MULT) | (op == OP_DIV);
    sa     = a[WIDTH-1] & is_sgn;
    sb     = b[WIDTH-1] & is_sgn;
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    div_nxt = {div_rem, acc_q[WIDTH-2:0], div_q};

    step_nxt = (state_q == S_DIV) ? div_nxt : mul_nxt;
    prod_fix = neg_q ? -mul_nxt : mul_nxt;
    quo_fix  = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
    rem_fix  = rneg_q ? -div_rem : div_rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = is_div & (b == '0);
          a_d     = a;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          dvs_d   = mag_b;
          cnt_d   = CW'(WIDTH);
          state_d = is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_nxt;
        cnt_d = cnt_q - CW'(1);
        // the final step commits even if a flush arrives with it
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          dbz_d   = dz_q;
          if (state_q == S_MUL) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dz_q) begin
            hi_d = a_q;
            lo_d = DIV0_LO;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else if (cancel) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign valid       = valid_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: 32- and 8-bit instances against
// an arithmetic reference model, plus cancel/reset cases.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, cancel32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy32, valid32, dbz32;
  logic        start8, cancel8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, valid8, dbz8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32),
    .a(a32), .b(b32), .cancel(cancel32), .busy(busy32),
    .valid(valid32), .hi(hi32), .lo(lo32),
    .div_by_zero(dbz32)
  );

  muldiv_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8),
    .a(a8), .b(b8), .cancel(cancel8), .busy(busy8),
    .valid(valid8), .hi(hi8), .lo(lo8),
    .div_by_zero(dbz8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: {hi,lo} packed at bit w
  function automatic void model(input int w,
                                input logic [1:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ed);
    logic [63:0] m, ux, uy, p;
    longint sx, sy, q, r;
    m  = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & m;
    uy = {32'd0, y} & m;
    sx = ux[w-1] ? longint'(ux) - longint'(64'd1 << w)
                 : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - longint'(64'd1 << w)
                 : longint'(uy);
    ed = 1'b0;
    p  = '0;
    if (o == OP_MULT) begin
      p = 64'(sx * sy);
    end else if (o == OP_MULTU) begin
      p = ux * uy;
    end else if (uy == 0) begin
      ed = 1'b1;
      p  = (ux << w) | m;
    end else begin
      if (o == OP_DIV) begin
        q = sx / sy;
        r = sx % sy;
      end else begin
        q = longint'(ux / uy);
        r = longint'(ux % uy);
      end
      p = ((64'(r) & m) << w) | (64'(q) & m);
    end
    eh = 32'((p >> w) & m);
    el = 32'(p & m);
  endfunction

  task automatic drive(input bit w8, input logic st,
                       input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    if (w8) begin
      start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = st; op32 = o; a32 = x; b32 = y;
    end
  endtask

  function automatic logic [63:0] f_busy(input bit w8);
    return w8 ? {63'd0, busy8} : {63'd0, busy32};
  endfunction
  function automatic logic [63:0] f_valid(input bit w8);
    return w8 ? {63'd0, valid8} : {63'd0, valid32};
  endfunction
  function automatic logic [63:0] f_hi(input bit w8);
    return w8 ? {56'd0, hi8} : {32'd0, hi32};
  endfunction
  function automatic logic [63:0] f_lo(input bit w8);
    return w8 ? {56'd0, lo8} : {32'd0, lo32};
  endfunction
  function automatic logic [63:0] f_dbz(input bit w8);
    return w8 ? {63'd0, dbz8} : {63'd0, dbz32};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the valid cycle
  task automatic run(input bit w8, input logic [1:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input bit cx);
    logic [31:0] eh, el;
    logic        ed;
    int          w;
    w = w8 ? 8 : 32;
    model(w, o, x, y, eh, el, ed);
    drive(w8, 1'b1, o, x, y);
    @(posedge clk); #1;
    drive(w8, 1'b0, o, x, y);
    for (int i = 0; i < w; i++) begin
      chk("busy_run", f_busy(w8), 64'd1);
      chk("early_valid", f_valid(w8), 64'd0);
      if (cx && i == w - 1) begin
        if (w8) cancel8 = 1'b1;
        else cancel32 = 1'b1;
      end
      @(posedge clk); #1;
    end
    cancel8  = 1'b0;
    cancel32 = 1'b0;
    chk("valid", f_valid(w8), 64'd1);
    chk("busy_done", f_busy(w8), 64'd0);
    chk("hi", f_hi(w8), {32'd0, eh});
    chk("lo", f_lo(w8), {32'd0, el});
    chk("dbz", f_dbz(w8), {63'd0, ed});
  endtask

  initial begin
    int vcnt;
    logic [1:0]  o;
    logic [31:0] x, y;

    rst = 1'b1;
    cancel32 = 1'b0;
    cancel8  = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", f_busy(1'b0), 64'd0);
    chk("rst_valid", f_valid(1'b0), 64'd0);
    chk("rst_hi", f_hi(1'b0), 64'd0);
    chk("rst_lo", f_lo(1'b0), 64'd0);
    chk("rst_dbz", f_dbz(1'b0), 64'd0);

    run(1'b0, OP_MULT, 32'hFFFFFFFD, 32'h5, 1'b0);
    chk("mult_hi", f_hi(1'b0), 64'hFFFFFFFF);
    chk("mult_lo", f_lo(1'b0), 64'hFFFFFFF1);
    run(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_hi", f_hi(1'b0), 64'hFFFFFFFE);
    chk("multu_lo", f_lo(1'b0), 64'h00000001);
    run(1'b0, OP_DIVU, 32'd64, 32'd7, 1'b0);
    chk("b2b_lo", f_lo(1'b0), 64'd9);
    chk("b2b_hi", f_hi(1'b0), 64'd1);
    run(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo", f_lo(1'b0), 64'hFFFFFFFD);
    chk("div_hi", f_hi(1'b0), 64'hFFFFFFFF);
    run(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("ovf_lo", f_lo(1'b0), 64'h80000000);
    chk("ovf_hi", f_hi(1'b0), 64'd0);
    run(1'b0, OP_DIVU, 32'h0000000A, 32'd0, 1'b0);
    chk("dz_flag", f_dbz(1'b0), 64'd1);
    chk("dz_hi", f_hi(1'b0), 64'h0000000A);
    chk("dz_lo", f_lo(1'b0), 64'hFFFFFFFF);

    // Completion-cycle flush must not suppress the commit
    run(1'b0, OP_MULT, 32'd7, 32'd6, 1'b1);
    chk("mul76_lo", f_lo(1'b0), 64'h2A);
    chk("mul76_hi", f_hi(1'b0), 64'd0);

    // Mid-operation cancel, with stray starts while busy
    drive(1'b0, 1'b1, OP_DIV, 32'd100, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_DIV, 32'd100, 32'd3);
    chk("cx_busy", f_busy(1'b0), 64'd1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk("cx_novalid", f_valid(1'b0), 64'd0);
      if (i == 3) drive(1'b0, 1'b1, OP_MULT, 32'd5, 32'd5);
      if (i == 5) drive(1'b0, 1'b0, OP_MULT, 32'd5, 32'd5);
    end
    cancel32 = 1'b1;
    @(posedge clk); #1;
    cancel32 = 1'b0;
    chk("cx_idle", f_busy(1'b0), 64'd0);
    chk("cx_valid", f_valid(1'b0), 64'd0);
    chk("cx_hi", f_hi(1'b0), 64'd0);
    chk("cx_lo", f_lo(1'b0), 64'h2A);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid32 !== 1'b0) vcnt++;
    end
    chk("cx_no_pulse", 64'(vcnt), 64'd0);

    // Cancel and start together in IDLE: nothing accepted
    drive(1'b0, 1'b1, OP_MULT, 32'd3, 32'd3);
    cancel32 = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_MULT, 32'd3, 32'd3);
    cancel32 = 1'b0;
    chk("cxst_busy", f_busy(1'b0), 64'd0);

    // Reset in the middle of an operation
    drive(1'b0, 1'b1, OP_MULT, 32'h1234, 32'h55);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_MULT, 32'h1234, 32'h55);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", f_busy(1'b0), 64'd0);
    chk("mrst_valid", f_valid(1'b0), 64'd0);
    chk("mrst_hi", f_hi(1'b0), 64'd0);
    chk("mrst_lo", f_lo(1'b0), 64'd0);
    chk("mrst_dbz", f_dbz(1'b0), 64'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid32 !== 1'b0) vcnt++;
    end
    chk("mrst_no_pulse", 64'(vcnt), 64'd0);

    // Narrow instance
    run(1'b1, OP_MULT, 32'h80, 32'h80, 1'b0);
    chk("w8_mul_hi", f_hi(1'b1), 64'h40);
    chk("w8_mul_lo", f_lo(1'b1), 64'h00);
    run(1'b1, OP_DIV, 32'h81, 32'h03, 1'b0);
    chk("w8_div_lo", f_lo(1'b1), 64'hD6);
    chk("w8_div_hi", f_hi(1'b1), 64'hFF);

    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      run(1'b0, o, x, y, 1'b0);
    end
    for (int k = 0; k < 30; k++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run(1'b1, o, x, y, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
